// File: rtl/alu_pkg.sv
// Shared ALU/commit definitions: condition codes, opcodes and commit FSM states.
package alu_pkg;

    localparam logic [1:0] COND_ALWAYS = 2'b00;
    localparam logic [1:0] COND_Z      = 2'b10;
    localparam logic [1:0] COND_C      = 2'b01;
    localparam logic [1:0] COND_RSVD   = 2'b11;

    localparam logic OP_ADD  = 1'b0;
    localparam logic OP_NAND = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        WRITE = 2'd2
    } commit_state_e;

endpackage

// File: rtl/cond_check.sv
// Conditional-execution check: decides whether an instruction with the given
// condition code may commit, based on the architectural flags. Shared with the
// branch unit, so it stays purely combinational.
module cond_check
    import alu_pkg::*;
(
    input  logic [1:0] cond_i,
    input  logic       flag_c_i,
    input  logic       flag_z_i,
    output logic       pass_o
);

    // Reserved code never passes, so a malformed instruction is dropped.
    always_comb begin
        pass_o = 1'b0;
        unique case (cond_i)
            COND_ALWAYS: pass_o = 1'b1;
            COND_Z:      pass_o = flag_z_i;
            COND_C:      pass_o = flag_c_i;
            COND_RSVD:   pass_o = 1'b0;
            default:     pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_commit.sv
// Writeback/commit stage: takes one ALU result per handshake, checks its
// condition code against the architectural C/Z flags and writes the register
// file. Owns the C and Z flags.
// Optional: define ALU_COMMIT_STATS_EN to add commit_cnt/skip_cnt counters.
module alu_commit
    import alu_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_result,
    input  logic                  in_carry,
    input  logic                  in_op,
    input  logic [1:0]            in_cond,
    input  logic [REG_ADDR_W-1:0] in_dest,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0]     rf_data,
    output logic                  flag_c,
    output logic                  flag_z,
`ifdef ALU_COMMIT_STATS_EN
    output logic [CNT_W-1:0]      commit_cnt,
    output logic [CNT_W-1:0]      skip_cnt,
`endif
    output logic                  skipped
);

    commit_state_e state_q, state_d;

    logic [DATA_W-1:0]     res_q;
    logic                  carry_q;
    logic                  op_q;
    logic [1:0]            cond_q;
    logic [REG_ADDR_W-1:0] dest_q;
    logic [REG_ADDR_W-1:0] rf_addr_q;
    logic [DATA_W-1:0]     rf_data_q;
    logic                  flag_c_q;
    logic                  flag_z_q;

    logic accept;
    logic pass;
    logic skip;
    logic we;

    // Flags are only written on the WRITE edge, so during EVAL they still hold
    // the previous instruction's result -- exactly what the condition needs.
    cond_check u_cond_check (
        .cond_i   (cond_q),
        .flag_c_i (flag_c_q),
        .flag_z_i (flag_z_q),
        .pass_o   (pass)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state and per-state strobes.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        skip    = 1'b0;
        we      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (pass) begin
                    state_d = WRITE;
                end else begin
                    skip    = 1'b1;
                    state_d = IDLE;
                end
            end
            WRITE: begin
                we      = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Instruction latch, write-port registers and flag update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_q     <= '0;
            carry_q   <= 1'b0;
            op_q      <= OP_ADD;
            cond_q    <= COND_ALWAYS;
            dest_q    <= '0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
            flag_c_q  <= 1'b0;
            flag_z_q  <= 1'b0;
        end else begin
            if (accept) begin
                res_q   <= in_result;
                carry_q <= in_carry;
                op_q    <= in_op;
                cond_q  <= in_cond;
                dest_q  <= in_dest;
            end
            // Load the write port only once the instruction is known to commit,
            // so a skipped instruction leaves the last written values in place.
            if (state_q == EVAL && pass) begin
                rf_addr_q <= dest_q;
                rf_data_q <= res_q;
            end
            if (we) begin
                flag_z_q <= (res_q == '0);
                if (op_q == OP_ADD) flag_c_q <= carry_q;
            end
        end
    end

`ifdef ALU_COMMIT_STATS_EN
    logic [CNT_W-1:0] commit_cnt_q;
    logic [CNT_W-1:0] skip_cnt_q;

    // Free-running wrap-around event counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            commit_cnt_q <= '0;
            skip_cnt_q   <= '0;
        end else begin
            if (we)   commit_cnt_q <= commit_cnt_q + CNT_W'(1);
            if (skip) skip_cnt_q   <= skip_cnt_q + CNT_W'(1);
        end
    end

    assign commit_cnt = commit_cnt_q;
    assign skip_cnt   = skip_cnt_q;
`endif

    assign in_ready = (state_q == IDLE);
    assign rf_we    = we;
    assign skipped  = skip;
    assign rf_addr  = rf_addr_q;
    assign rf_data  = rf_data_q;
    assign flag_c   = flag_c_q;
    assign flag_z   = flag_z_q;

endmodule

// File: doc/alu_commit.md
Name: alu_commit

Overview:
- Writeback/commit stage that consumes one ALU result per handshake, evaluates the instruction's conditional-execution code against the architectural carry/zero flags, and commits the result to the register file.
- Owns the architectural C and Z flag registers that the ALU's conditional ops (ADC/ADZ/NDC/NDZ) depend on.
- Sits between the ALU output and the register-file write port in the multicycle datapath.

Parameters:
- DATA_W, 16, width of ALU result and register-file data.
- REG_ADDR_W, 3, register-file address width (8 registers).
- CNT_W, 16, width of the statistics counters (used only with the optional feature).

Ports:
- clk  input  1  single clock, all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  ALU result and control fields are valid.
- in_ready  output  1  block can accept a new result.
- in_result  input  DATA_W  ALU output (add or nand result).
- in_carry  input  1  carry out from the ALU adder.
- in_op  input  1  0 = add-type, 1 = nand-type.
- in_cond  input  2  00 always, 10 write-if-Z, 01 write-if-C, 11 reserved.
- in_dest  input  REG_ADDR_W  destination register.
- rf_we  output  1  register-file write strobe, one-cycle pulse.
- rf_addr  output  REG_ADDR_W  write address.
- rf_data  output  DATA_W  write data.
- flag_c  output  1  architectural carry flag.
- flag_z  output  1  architectural zero flag.
- skipped  output  1  one-cycle pulse when a condition fails and the instruction is dropped.

Behaviour:
- Reset (async, reset_n=0): state IDLE; in_ready=1; rf_we=0; skipped=0; rf_addr=0; rf_data=0; flag_c=0; flag_z=0; counters=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, latch result, carry, op, cond and dest, then go to EVAL.
  - EVAL: in_ready=0. Compute pass:
    - 00 -> 1
    - 10 -> flag_z (the pre-instruction value)
    - 01 -> flag_c (the pre-instruction value)
    - 11 -> 0
  - EVAL transition: pass=1 -> WRITE; pass=0 -> pulse skipped, return to IDLE.
  - WRITE: rf_we=1 for exactly one cycle, with rf_addr=dest and rf_data=result.
    - Same edge: flag_z <= (result==0).
    - Same edge, add-type only: flag_c <= carry. Nand-type leaves C unchanged.
    - Then return to IDLE.
- Latency: accept at edge N; skipped at N+1 or rf_we at N+2; in_ready re-asserts at N+2 (skip) or N+3 (write).
- Skipped instructions modify neither flags nor the register file.
- in_valid while in_ready=0 is ignored; the producer holds its data until it is accepted.
- A condition is always checked against flags committed by the previous instruction, never the current one.
- rf_addr and rf_data hold their last values when rf_we=0.
- Reset mid-EVAL or mid-WRITE: the instruction is abandoned, no write occurs, and flags are cleared.
- Zero detection uses the full DATA_W width. Carry is taken as-is; the block does not recompute it.

Optional Feature:
- Macro: ALU_COMMIT_STATS_EN.
- Defined: adds outputs commit_cnt[CNT_W] and skip_cnt[CNT_W].
  - commit_cnt increments on each rf_we pulse; skip_cnt increments on each skipped pulse.
  - Both counters wrap modulo 2^CNT_W and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg:
  - Condition codes COND_ALWAYS=2'b00, COND_Z=2'b10, COND_C=2'b01, COND_RSVD=2'b11.
  - Opcodes OP_ADD=1'b0, OP_NAND=1'b1.
  - Commit FSM state enum {IDLE, EVAL, WRITE}.
- One natural sub-module: cond_check, combinational (cond, flag_c, flag_z -> pass), reused by the branch unit.

Test Plan:
- Reset, then ADD cond=00, result=0x0000, carry=1, dest=3 -> rf_we at N+2, addr=3, data=0x0000; flag_z=1, flag_c=1.
- Flags C=0, then ADC cond=01, result=0x1234 -> skipped pulse at N+1, no rf_we, flags unchanged, in_ready back at N+2.
- Flags Z=1, then NDZ cond=10, in_op=1, result=0xFFFF, carry=1 -> write 0xFFFF; flag_z=0; flag_c stays at its prior value.
- cond=11, any data -> skipped; flags and register file untouched.
- Back-to-back in_valid held high for two ops -> second accepted only when in_ready=1; each produces exactly one rf_we.
- reset_n low during WRITE -> no rf_we, flags=0, in_ready=1 immediately. With ALU_COMMIT_STATS_EN: 3 commits and 2 skips -> commit_cnt=3, skip_cnt=2.
